uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter in the user project area. It drives `mprj_io[6]`, the serial line the top-level simulation UART monitor decodes. Firmware running the FIR/matmul/qsort workloads pushes bytes through a valid/ready write port into a small FIFO. The block serialises them LSB-first at a fixed baud divisor, back-to-back, with no CPU stall unless the FIFO is full.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 52 +++++
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; full/empty derive from that count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO-fed, LSB-first, back-to-back frames at a fixed baud divisor.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4167,
  parameter int DEPTH        = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   tx_en,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   tx_done,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t    state;
  uart_tx_state_t    state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [7:0]        shift_next;
  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              baud_last;
  logic              tx_q;
  logic              tx_next;

  uart_sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .push (wr_valid),
    .pop  (pop),
    .wdata(wr_data),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  assign wr_ready  = !fifo_full;
  assign baud_last = (baud_cnt == BAUD_MAX);
  assign busy      = (state != IDLE);
  assign tx_done   = (state == STOP) && baud_last;
  assign tx        = tx_q;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    shift_next = shift;
    case (state)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: begin
        if (baud_last) state_next = DATA;
      end
      DATA: begin
        if (baud_last) begin
          shift_next = shift >> 1;
          if (bit_idx == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (tx_en && !fifo_empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (pop) shift_next = fifo_rdata;
  end

  // The line level is decided from the next state so tx changes on the same edge as the FSM.
  always_comb begin
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state <= state_next;
      shift <= shift_next;
      tx_q  <= tx_next;
      if (state_next != state || baud_last || state == IDLE)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + BAUD_W'(1);
      if (state != DATA)
        bit_idx <= '0;
      else if (baud_last)
        bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, a line decoder pops and compares them.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = UART_FRAME_BITS * CPB;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   tx_en = 1'b1;
  logic                   wr_valid = 1'b0;
  logic [7:0]             wr_data = 8'h00;
  logic                   wr_ready;
  logic                   tx;
  logic                   busy;
  logic                   tx_done;
  logic [$clog2(DEPTH):0] fifo_level;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         accepts = 0;
  int         starts = 0;
  logic [7:0] exp_q[$];
  int         done_times[$];
  bit         dec_active = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .tx_en     (tx_en),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Stimulus is driven at a negedge; returns on the negedge after the accepting edge.
  task automatic applyStimulus(input logic [7:0] d, input int budget);
    int n;
    wr_valid = 1'b1;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_accept", int'(wr_ready), 1);
    if (wr_ready) @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && n < budget);
    checkOutput("tx_done_seen", int'(tx_done), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || dec_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", int'(exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        accepts = 0;
      end else if (wr_valid && wr_ready) begin
        exp_q.push_back(wr_data);
        accepts++;
      end
    end
  end

  // Line decoder: samples mid-bit, pops the scoreboard at the stop bit, tracks expected level.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst) begin
        dec_active = 1'b0;
        dec_cnt    = 0;
        starts     = 0;
      end else begin
        checkOutput("tx_done", int'(tx_done), int'(dec_active && dec_cnt == FRAME - 1));
        if (tx_done) done_times.push_back(cyc);
        if (dec_active) begin
          if (dec_cnt % CPB == CPB / 2) begin
            if (dec_cnt / CPB == 0) begin
              checkOutput("start_bit", int'(tx), 0);
            end else if (dec_cnt / CPB <= UART_DATA_BITS) begin
              dec_byte = {tx, dec_byte[7:1]};
            end else begin
              checkOutput("stop_bit", int'(tx), 1);
              if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL data: got frame 0x%0h expected no frame (cycle %0d)", dec_byte, cyc);
              end else begin
                exp_b = exp_q.pop_front();
                checkOutput("data", int'(dec_byte), int'(exp_b));
              end
            end
          end
          if (dec_cnt == FRAME - 1) dec_active = 1'b0;
          else dec_cnt++;
        end else if (tx == 1'b0) begin
          dec_active = 1'b1;
          dec_cnt    = 1;
          starts++;
        end
        checkOutput("fifo_level", int'(fifo_level), accepts - starts);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_tx", int'(tx), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_tx_done", int'(tx_done), 0);
    checkOutput("rst_level", int'(fifo_level), 0);
    checkOutput("rst_wr_ready", int'(wr_ready), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single byte");
    applyStimulus(8'h41, 20);
    checkOutput("single_level_n", int'(fifo_level), 1);
    checkOutput("single_tx_n", int'(tx), 1);
    checkOutput("single_busy_n", int'(busy), 0);
    @(negedge clk);
    checkOutput("single_tx_n1", int'(tx), 0);
    checkOutput("single_busy_n1", int'(busy), 1);
    checkOutput("single_level_n1", int'(fifo_level), 0);
    wait_done(FRAME + 5);
    @(negedge clk);
    checkOutput("single_busy_after", int'(busy), 0);
    checkOutput("single_tx_after", int'(tx), 1);
    wait_drain(100);

    $display("[TB] fill");
    tx_en = 1'b0;
    applyStimulus(8'h00, 5);
    applyStimulus(8'hFF, 5);
    applyStimulus(8'h55, 5);
    applyStimulus(8'hAA, 5);
    checkOutput("fill_level_full", int'(fifo_level), 4);
    checkOutput("fill_wr_ready_full", int'(wr_ready), 0);
    wr_valid = 1'b1;
    wr_data  = 8'h0F;
    repeat (3) @(negedge clk);
    checkOutput("fill_level_held", int'(fifo_level), 4);
    checkOutput("fill_wr_ready_held", int'(wr_ready), 0);
    checkOutput("fill_busy_gated", int'(busy), 0);
    done_times.delete();
    tx_en = 1'b1;
    applyStimulus(8'h0F, 10);
    wait_drain(8 * FRAME);
    checkOutput("fill_done_count", done_times.size(), 5);
    for (int i = 1; i < done_times.size(); i++)
      checkOutput("fill_done_spacing", done_times[i] - done_times[i-1], FRAME);

    $display("[TB] push on pop edge");
    applyStimulus(8'hA1, 5);
    applyStimulus(8'hB2, 5);
    checkOutput("pp_level_before", int'(fifo_level), 1);
    wait_done(FRAME + 5);
    applyStimulus(8'h7E, 2);
    checkOutput("pp_level_after", int'(fifo_level), 1);
    wait_drain(4 * FRAME);

    $display("[TB] tx_en gating");
    tx_en = 1'b0;
    applyStimulus(8'h12, 5);
    applyStimulus(8'h34, 5);
    repeat (10) @(negedge clk);
    checkOutput("gate_tx", int'(tx), 1);
    checkOutput("gate_busy", int'(busy), 0);
    checkOutput("gate_level", int'(fifo_level), 2);
    tx_en = 1'b1;
    repeat (15) @(negedge clk);
    tx_en = 1'b0;
    wait_done(FRAME + 5);
    @(negedge clk);
    checkOutput("gate_mid_busy", int'(busy), 0);
    checkOutput("gate_mid_level", int'(fifo_level), 1);
    repeat (8) @(negedge clk);
    checkOutput("gate_hold_tx", int'(tx), 1);
    checkOutput("gate_hold_busy", int'(busy), 0);
    tx_en = 1'b1;
    wait_drain(3 * FRAME);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hC3, 5);
    applyStimulus(8'h5A, 5);
    repeat (17) @(negedge clk);
    checkOutput("rst_mid_bit3", int'(tx), 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_tx", int'(tx), 1);
    checkOutput("rst_mid_level", int'(fifo_level), 0);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_wr_ready", int'(wr_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'h96, 5);
    wait_drain(3 * FRAME);

    $display("[TB] random traffic");
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        tx_en = 1'b0;
        repeat ($urandom_range(1, 60)) @(negedge clk);
        tx_en = 1'b1;
      end
      repeat ($urandom_range(0, 50)) @(negedge clk);
      applyStimulus(8'($urandom), 500);
    end
    wait_drain(40 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
